// File: rtl/vrp_arb_grant_rr_if.sv
// Bundle of the arbiter's request side (WIDTH requesters) and its single granted output.
// Handshake: a beat moves on a rising clk edge where valid and ready are both high; valid/payload/last must hold until then.
interface vrp_arb_grant_rr_if #(
  parameter int WIDTH     = 8,
  parameter int PLD_WIDTH = 32
) ();
  localparam int IW = $clog2(WIDTH);

  logic [WIDTH-1:0]     v_vld_s;
  logic [PLD_WIDTH-1:0] v_pld_s [WIDTH];
  logic [WIDTH-1:0]     v_last_s;
  logic [WIDTH-1:0]     v_rdy_s;
  logic                 vld_m;
  logic                 rdy_m;
  logic [PLD_WIDTH-1:0] pld_m;
  logic                 last_m;
  logic [IW-1:0]        grant_idx;

  // slave: the arbiter itself; master: requesters plus the downstream consumer.
  modport slave (
    input  v_vld_s, v_pld_s, v_last_s, rdy_m,
    output v_rdy_s, vld_m, pld_m, last_m, grant_idx
  );
  modport master (
    output v_vld_s, v_pld_s, v_last_s, rdy_m,
    input  v_rdy_s, vld_m, pld_m, last_m, grant_idx
  );
endinterface

// File: rtl/vrp_arb_grant_rr.sv
// N:1 packet arbiter: fixed-priority or round-robin selection, grant held for a whole packet,
// optional one-entry output register.
module vrp_arb_grant_rr #(
  parameter int WIDTH     = 8,
  parameter int PLD_WIDTH = 32,
  parameter bit OUT_REG   = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rr_en,
  vrp_arb_grant_rr_if.slave          bus,
  output logic                       dbg_lock,
  output logic [$clog2(WIDTH)-1:0]   dbg_ptr
);
  localparam int IW = $clog2(WIDTH);
  typedef logic [IW-1:0] idx_t;

  idx_t ptr;
  idx_t lock_idx;
  logic lock;
  idx_t sel_idx;
  logic sel_vld;
  logic sel_last;
  logic up_rdy;
  logic accept;

  // Modulo-WIDTH add, so non-power-of-2 WIDTH wraps at WIDTH rather than 2^IW.
  function automatic idx_t wrap_idx(input idx_t base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= WIDTH) s = s - WIDTH;
    return idx_t'(s);
  endfunction

  // Descending loops let the last hit (lowest index / nearest to ptr) win.
  always_comb begin
    sel_idx = '0;
    sel_vld = 1'b0;
    if (lock) begin
      sel_idx = lock_idx;
      sel_vld = bus.v_vld_s[lock_idx];
    end else if (!rr_en) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (bus.v_vld_s[i]) begin
          sel_idx = idx_t'(i);
          sel_vld = 1'b1;
        end
      end
    end else begin
      for (int k = WIDTH - 1; k >= 0; k--) begin
        if (bus.v_vld_s[wrap_idx(ptr, k)]) begin
          sel_idx = wrap_idx(ptr, k);
          sel_vld = 1'b1;
        end
      end
    end
  end

  assign sel_last = bus.v_last_s[sel_idx];
  assign accept   = sel_vld & up_rdy & ~rst;

  always_comb begin
    bus.v_rdy_s = '0;
    if (accept) bus.v_rdy_s[sel_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
    end else if (accept) begin
      if (sel_last) begin
        lock <= 1'b0;
        if (rr_en) ptr <= wrap_idx(sel_idx, 1);
      end else begin
        lock     <= 1'b1;
        lock_idx <= sel_idx;
      end
    end
  end

  assign dbg_lock = lock;
  assign dbg_ptr  = ptr;

  generate
    if (OUT_REG) begin : g_reg
      logic                 o_vld;
      logic [PLD_WIDTH-1:0] o_pld;
      logic                 o_last;
      idx_t                 o_idx;

      assign up_rdy = ~o_vld | bus.rdy_m;

      // Data is only loaded on a real upstream accept, so a drained entry keeps its last value.
      always_ff @(posedge clk) begin
        if (rst) begin
          o_vld  <= 1'b0;
          o_pld  <= '0;
          o_last <= 1'b0;
          o_idx  <= '0;
        end else begin
          if (up_rdy) o_vld <= sel_vld;
          if (accept) begin
            o_pld  <= bus.v_pld_s[sel_idx];
            o_last <= sel_last;
            o_idx  <= sel_idx;
          end
        end
      end

      assign bus.vld_m     = o_vld & ~rst;
      assign bus.pld_m     = o_pld;
      assign bus.last_m    = o_last;
      assign bus.grant_idx = o_idx;
    end else begin : g_comb
      logic out_vld;

      assign up_rdy  = bus.rdy_m;
      assign out_vld = sel_vld & ~rst;

      assign bus.vld_m     = out_vld;
      assign bus.pld_m     = out_vld ? bus.v_pld_s[sel_idx] : '0;
      assign bus.last_m    = out_vld ? sel_last : 1'b0;
      assign bus.grant_idx = out_vld ? sel_idx : '0;
    end
  endgenerate
endmodule

// File: tb/tb_vrp_arb_grant_rr.sv
// Bench for vrp_arb_grant_rr: an 8-wide combinational instance and a 5-wide registered instance.
module tb_vrp_arb_grant_rr;
  logic clk;
  logic rst;
  logic rr_en0;
  logic rr_en1;
  logic lock0;
  logic lock1;
  logic [2:0] ptr0;
  logic [2:0] ptr1;

  vrp_arb_grant_rr_if #(.WIDTH(8), .PLD_WIDTH(32)) i0 ();
  vrp_arb_grant_rr_if #(.WIDTH(5), .PLD_WIDTH(32)) i1 ();

  vrp_arb_grant_rr #(.WIDTH(8), .PLD_WIDTH(32), .OUT_REG(1'b0)) dut0 (
    .clk(clk), .rst(rst), .rr_en(rr_en0), .bus(i0), .dbg_lock(lock0), .dbg_ptr(ptr0)
  );
  vrp_arb_grant_rr #(.WIDTH(5), .PLD_WIDTH(32), .OUT_REG(1'b1)) dut1 (
    .clk(clk), .rst(rst), .rr_en(rr_en1), .bus(i1), .dbg_lock(lock1), .dbg_ptr(ptr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp;

  function automatic logic [31:0] pld_of(input int r, input int b);
    return 32'hA000 + 32'(r << 8) + 32'(b);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    i0.v_vld_s  = '0;
    i0.v_last_s = '0;
    i0.rdy_m    = 1'b0;
    for (int i = 0; i < 8; i++) i0.v_pld_s[i] = '0;
  endtask

  task automatic idle1();
    i1.v_vld_s  = '0;
    i1.v_last_s = '0;
    i1.rdy_m    = 1'b0;
    for (int i = 0; i < 5; i++) i1.v_pld_s[i] = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rr_en0 = 1'b1; rr_en1 = 1'b1;
    i0.v_vld_s = '1; i0.v_last_s = '1; i0.rdy_m = 1'b1;
    i1.v_vld_s = '1; i1.v_last_s = '1; i1.rdy_m = 1'b1;
    for (int i = 0; i < 8; i++) i0.v_pld_s[i] = pld_of(i, 0);
    for (int i = 0; i < 5; i++) i1.v_pld_s[i] = pld_of(i, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (i0.vld_m !== 1'b0) begin n_fail++; $display("FAIL rst_vld0: got %0b want 0", i0.vld_m); end
    n_checks++; if (i0.v_rdy_s !== 8'h00) begin n_fail++; $display("FAIL rst_rdy0: got %0h want 0", i0.v_rdy_s); end
    n_checks++; if (lock0 !== 1'b0) begin n_fail++; $display("FAIL rst_lock0: got %0b want 0", lock0); end
    n_checks++; if (ptr0 !== 3'd0) begin n_fail++; $display("FAIL rst_ptr0: got %0d want 0", ptr0); end
    n_checks++; if (i1.vld_m !== 1'b0) begin n_fail++; $display("FAIL rst_vld1: got %0b want 0", i1.vld_m); end
    n_checks++; if (i1.v_rdy_s !== 5'h00) begin n_fail++; $display("FAIL rst_rdy1: got %0h want 0", i1.v_rdy_s); end
    n_checks++; if (i1.pld_m !== 32'h0) begin n_fail++; $display("FAIL rst_pld1: got %0h want 0", i1.pld_m); end
    step();
    rst = 1'b0;
    idle0();
    idle1();
    step();
  endtask

  task automatic test_fixed_priority();
    rr_en0 = 1'b0;
    i0.v_vld_s = 8'b0010_1100; i0.v_last_s = '1; i0.rdy_m = 1'b1;
    for (int i = 0; i < 8; i++) i0.v_pld_s[i] = pld_of(i, 0);
    for (int c = 0; c < 4; c++) begin
      exp_q.push_back({1'b1, pld_of(2, 0)});
      @(negedge clk);
      n_checks++; if (i0.grant_idx !== 3'd2) begin n_fail++; $display("FAIL fp_idx: got %0d want 2", i0.grant_idx); end
      n_checks++; if (i0.v_rdy_s !== 8'h04) begin n_fail++; $display("FAIL fp_rdy: got %0h want 04", i0.v_rdy_s); end
      exp = exp_q.pop_front();
      n_checks++;
      if ({i0.vld_m & i0.rdy_m, i0.last_m, i0.pld_m} !== {1'b1, exp}) begin
        n_fail++; $display("FAIL fp_beat: got hs=%0b %0h want hs=1 %0h", i0.vld_m & i0.rdy_m, {i0.last_m, i0.pld_m}, exp);
      end
      step();
    end
    i0.rdy_m = 1'b0;
    @(negedge clk);
    n_checks++; if (i0.vld_m !== 1'b1) begin n_fail++; $display("FAIL fp_vld_no_rdy: got %0b want 1", i0.vld_m); end
    n_checks++; if (i0.v_rdy_s !== 8'h00) begin n_fail++; $display("FAIL fp_rdy_no_rdy: got %0h want 0", i0.v_rdy_s); end
    n_checks++; if (ptr0 !== 3'd0) begin n_fail++; $display("FAIL fp_ptr: got %0d want 0", ptr0); end
    step();
    idle0();
  endtask

  task automatic test_round_robin();
    rr_en0 = 1'b1;
    i0.v_vld_s = '1; i0.v_last_s = '1; i0.rdy_m = 1'b1;
    for (int i = 0; i < 8; i++) i0.v_pld_s[i] = pld_of(i, 0);
    for (int c = 0; c < 9; c++) begin
      exp_q.push_back({1'b1, pld_of(c % 8, 0)});
      @(negedge clk);
      n_checks++; if (i0.grant_idx !== 3'(c % 8)) begin n_fail++; $display("FAIL rr_idx: got %0d want %0d", i0.grant_idx, c % 8); end
      exp = exp_q.pop_front();
      n_checks++;
      if ({i0.vld_m & i0.rdy_m, i0.last_m, i0.pld_m} !== {1'b1, exp}) begin
        n_fail++; $display("FAIL rr_beat: got %0h want %0h", {i0.last_m, i0.pld_m}, exp);
      end
      if (c == 8) begin
        n_checks++; if (ptr0 !== 3'd0) begin n_fail++; $display("FAIL rr_ptr_wrap: got %0d want 0", ptr0); end
      end
      step();
    end
    n_checks++; if (ptr0 !== 3'd1) begin n_fail++; $display("FAIL rr_ptr_end: got %0d want 1", ptr0); end
    idle0();
  endtask

  task automatic test_multi_beat();
    int hs;
    int b3;
    logic [7:0] acc;
    logic [7:0] oh;
    hs = 0; b3 = 0;
    rr_en0 = 1'b1; i0.rdy_m = 1'b1;
    i0.v_vld_s = 8'b0010_1001;
    i0.v_last_s = 8'b0010_0001;
    i0.v_pld_s[0] = pld_of(0, 0);
    i0.v_pld_s[3] = pld_of(3, 0);
    i0.v_pld_s[5] = pld_of(5, 0);
    for (int b = 0; b < 4; b++) exp_q.push_back({b == 3, pld_of(3, b)});
    exp_q.push_back({1'b1, pld_of(5, 0)});
    exp_q.push_back({1'b1, pld_of(0, 0)});
    for (int c = 0; c < 20 && hs < 6; c++) begin
      @(negedge clk);
      acc = i0.v_vld_s & i0.v_rdy_s;
      if (i0.vld_m & i0.rdy_m) begin
        exp = exp_q.pop_front();
        oh = 8'b1 << exp[10:8];
        n_checks++; if ({i0.last_m, i0.pld_m} !== exp) begin n_fail++; $display("FAIL mb_beat: got %0h want %0h", {i0.last_m, i0.pld_m}, exp); end
        n_checks++; if (i0.grant_idx !== exp[10:8]) begin n_fail++; $display("FAIL mb_idx: got %0d want %0d", i0.grant_idx, exp[10:8]); end
        n_checks++; if (i0.v_rdy_s !== oh) begin n_fail++; $display("FAIL mb_rdy: got %0h want %0h", i0.v_rdy_s, oh); end
        n_checks++; if (lock0 !== (hs >= 1 && hs <= 3)) begin n_fail++; $display("FAIL mb_lock: got %0b at beat %0d", lock0, hs); end
        hs++;
      end
      step();
      if (acc[3]) begin
        if (b3 == 3) i0.v_vld_s[3] = 1'b0;
        else begin
          b3++;
          i0.v_pld_s[3] = pld_of(3, b3);
          i0.v_last_s[3] = (b3 == 3);
        end
      end
      if (acc[5]) i0.v_vld_s[5] = 1'b0;
      if (acc[0]) i0.v_vld_s[0] = 1'b0;
    end
    n_checks++; if (hs != 6) begin n_fail++; $display("FAIL mb_timeout: got %0d beats want 6", hs); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mb_queue: got %0d left want 0", exp_q.size()); end
    n_checks++; if (ptr0 !== 3'd1) begin n_fail++; $display("FAIL mb_ptr: got %0d want 1", ptr0); end
    idle0();
  endtask

  task automatic test_lock_stall();
    rr_en0 = 1'b1; i0.rdy_m = 1'b1;
    i0.v_vld_s = 8'h40; i0.v_last_s = 8'h00; i0.v_pld_s[6] = pld_of(6, 0);
    @(negedge clk);
    n_checks++; if (i0.v_rdy_s !== 8'h40) begin n_fail++; $display("FAIL ls_first: got %0h want 40", i0.v_rdy_s); end
    step();
    i0.v_vld_s = 8'h46; i0.v_last_s = 8'h06; i0.rdy_m = 1'b0;
    i0.v_pld_s[1] = pld_of(1, 0); i0.v_pld_s[2] = pld_of(2, 0); i0.v_pld_s[6] = pld_of(6, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({i0.vld_m, i0.grant_idx, i0.v_rdy_s, lock0, i0.pld_m} !== {1'b1, 3'd6, 8'h00, 1'b1, pld_of(6, 1)}) begin
        n_fail++; $display("FAIL ls_stall: got vld=%0b idx=%0d rdy=%0h lock=%0b pld=%0h want 1 6 0 1 %0h",
          i0.vld_m, i0.grant_idx, i0.v_rdy_s, lock0, i0.pld_m, pld_of(6, 1));
      end
      step();
    end
    i0.v_vld_s[6] = 1'b0; i0.rdy_m = 1'b1;
    @(negedge clk);
    n_checks++; if ({i0.vld_m, i0.v_rdy_s} !== 9'h0) begin n_fail++; $display("FAIL ls_drop: got vld=%0b rdy=%0h want 0 0", i0.vld_m, i0.v_rdy_s); end
    step();
    i0.v_vld_s[6] = 1'b1; i0.v_last_s[6] = 1'b1;
    @(negedge clk);
    n_checks++; if ({i0.grant_idx, i0.last_m, i0.v_rdy_s} !== {3'd6, 1'b1, 8'h40}) begin
      n_fail++; $display("FAIL ls_last: got idx=%0d last=%0b rdy=%0h want 6 1 40", i0.grant_idx, i0.last_m, i0.v_rdy_s);
    end
    step();
    i0.v_vld_s[6] = 1'b0;
    @(negedge clk);
    n_checks++; if ({lock0, ptr0} !== {1'b0, 3'd7}) begin n_fail++; $display("FAIL ls_state: got lock=%0b ptr=%0d want 0 7", lock0, ptr0); end
    n_checks++; if (i0.grant_idx !== 3'd1) begin n_fail++; $display("FAIL ls_next: got %0d want 1", i0.grant_idx); end
    step();
    idle0();
  endtask

  task automatic test_reset_mid_packet();
    rr_en0 = 1'b1; i0.rdy_m = 1'b1;
    i0.v_vld_s = 8'h10; i0.v_last_s = 8'h00;
    for (int b = 0; b < 2; b++) begin
      i0.v_pld_s[4] = pld_of(4, b);
      @(negedge clk);
      n_checks++; if (i0.grant_idx !== 3'd4) begin n_fail++; $display("FAIL rm_idx: got %0d want 4", i0.grant_idx); end
      step();
    end
    n_checks++; if (lock0 !== 1'b1) begin n_fail++; $display("FAIL rm_locked: got %0b want 1", lock0); end
    i0.v_pld_s[4] = pld_of(4, 2);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({i0.vld_m, i0.v_rdy_s} !== 9'h0) begin n_fail++; $display("FAIL rm_rst_out: got vld=%0b rdy=%0h want 0 0", i0.vld_m, i0.v_rdy_s); end
    step();
    rst = 1'b0;
    i0.v_vld_s = '1; i0.v_last_s = 8'hEF;
    for (int i = 0; i < 8; i++) if (i != 4) i0.v_pld_s[i] = pld_of(i, 0);
    @(negedge clk);
    n_checks++; if ({lock0, ptr0} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL rm_state: got lock=%0b ptr=%0d want 0 0", lock0, ptr0); end
    n_checks++; if ({i0.vld_m, i0.grant_idx} !== {1'b1, 3'd0}) begin n_fail++; $display("FAIL rm_restart: got vld=%0b idx=%0d want 1 0", i0.vld_m, i0.grant_idx); end
    step();
    idle0();
  endtask

  task automatic test_out_reg();
    int hs;
    int c;
    hs = 0; c = 0;
    rr_en1 = 1'b1;
    i1.v_vld_s = '1; i1.v_last_s = '1;
    for (int i = 0; i < 5; i++) i1.v_pld_s[i] = 32'h50 + 32'(i);
    for (int k = 0; k < 21; k++) exp_q.push_back({1'b1, 32'h50 + 32'(k % 5)});
    while (hs < 20 && c < 80) begin
      i1.rdy_m = (c < 20) ? (c % 2 == 0) : 1'b1;
      @(negedge clk);
      if (c == 0) begin
        n_checks++; if (i1.vld_m !== 1'b0) begin n_fail++; $display("FAIL or_latency: got %0b want 0", i1.vld_m); end
      end
      if (c >= 20) begin
        n_checks++; if (i1.vld_m !== 1'b1) begin n_fail++; $display("FAIL or_throughput: got %0b want 1 at cycle %0d", i1.vld_m, c); end
      end
      n_checks++; if (!$onehot0(i1.v_rdy_s)) begin n_fail++; $display("FAIL or_rdy_onehot: got %0h", i1.v_rdy_s); end
      if (i1.vld_m & i1.rdy_m) begin
        exp = exp_q.pop_front();
        n_checks++; if ({i1.last_m, i1.pld_m} !== exp) begin n_fail++; $display("FAIL or_beat: got %0h want %0h", {i1.last_m, i1.pld_m}, exp); end
        n_checks++; if (i1.grant_idx !== 3'(exp[31:0] - 32'h50)) begin n_fail++; $display("FAIL or_idx: got %0d want %0d", i1.grant_idx, exp[31:0] - 32'h50); end
        hs++;
      end
      step();
      c++;
    end
    n_checks++; if (hs != 20) begin n_fail++; $display("FAIL or_timeout: got %0d beats want 20", hs); end
    idle1();
    i1.rdy_m = 1'b1;
    @(negedge clk);
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    n_checks++; if ({i1.vld_m, i1.last_m, i1.pld_m} !== {1'b1, exp}) begin n_fail++; $display("FAIL or_tail: got vld=%0b %0h want 1 %0h", i1.vld_m, {i1.last_m, i1.pld_m}, exp); end
    step();
    @(negedge clk);
    n_checks++; if ({i1.vld_m, i1.pld_m} !== {1'b0, 32'h50}) begin n_fail++; $display("FAIL or_drain: got vld=%0b pld=%0h want 0 50", i1.vld_m, i1.pld_m); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL or_queue: got %0d left want 0", exp_q.size()); end
    step();
  endtask

  initial begin
    rst = 1'b1; rr_en0 = 1'b0; rr_en1 = 1'b0;
    idle0();
    idle1();
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_multi_beat();
    test_lock_stall();
    test_reset_mid_packet();
    test_out_reg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
